// File: rtl/txll_link_tx.sv
// txll_link_tx: SATA transmit link framer draining the TX frame FIFO toward the scrambler/PHY.
module txll_link_tx #(
    parameter logic [31:0] C_CRC_INIT = 32'h52325032,
    parameter int          C_WTRM_MAX = 1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [35:0] rd_do,
    input  logic        rd_empty,
    output logic        rd_en,
    output logic        eof_poped,
    output logic [31:0] out_data,
    output logic        out_isk,
    input  logic        out_rdy,
    input  logic        rx_r_rdy,
    input  logic        rx_r_ok,
    input  logic        rx_r_err,
    input  logic        rx_hold,
    input  logic        rx_sync,
    output logic        tx_done,
    output logic        tx_err
);
    localparam logic [31:0] P_SYNC  = 32'hB5B5957C;
    localparam logic [31:0] P_XRDY  = 32'h5757B57C;
    localparam logic [31:0] P_SOF   = 32'h3737B57C;
    localparam logic [31:0] P_EOF   = 32'hD5D5B57C;
    localparam logic [31:0] P_WTRM  = 32'h5858B57C;
    localparam logic [31:0] P_HOLD  = 32'hD5D5AA7C;
    localparam logic [31:0] P_HOLDA = 32'h9595AA7C;
    localparam int CW = $clog2(C_WTRM_MAX + 1);
    localparam logic [CW-1:0] WTRM_LAST = CW'(C_WTRM_MAX - 1);

    typedef enum logic [2:0] {S_IDLE, S_XRDY, S_SOF, S_DATA, S_CRC, S_EOF, S_WTRM, S_FLUSH} state_t;

    state_t state;
    logic [31:0] crc;
    logic [CW-1:0] wtrm_cnt;
    logic pop_eof;
    logic unused_bits;

    function automatic logic [31:0] crc32(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 31; i >= 0; i--)
            r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? 32'h04C11DB7 : 32'h0);
        return r;
    endfunction

    assign rd_en = (state == S_IDLE)  ? out_rdy & ~rd_empty & ~rd_do[35] :
                   (state == S_DATA)  ? out_rdy & ~rd_empty & ~rx_hold :
                   (state == S_FLUSH) ? ~rd_empty : 1'b0;
    assign pop_eof = rd_en & rd_do[34];
    assign unused_bits = ^rd_do[33:32];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            out_data  <= P_SYNC;
            out_isk   <= 1'b1;
            crc       <= C_CRC_INIT;
            wtrm_cnt  <= '0;
            eof_poped <= 1'b0;
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
        end else begin
            eof_poped <= pop_eof;
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
            // FLUSH drains the aborted frame whether or not the PHY is accepting
            if (state == S_FLUSH) begin
                if (out_rdy) begin
                    out_data <= P_SYNC;
                    out_isk  <= 1'b1;
                end
                if (pop_eof) state <= S_IDLE;
            end else if (out_rdy) begin
                out_isk <= 1'b1;
                if (rx_sync && state inside {S_XRDY, S_SOF, S_DATA, S_CRC, S_EOF}) begin
                    out_data <= P_SYNC;
                    tx_err   <= 1'b1;
                    state    <= (pop_eof || state == S_CRC || state == S_EOF) ? S_IDLE : S_FLUSH;
                end else begin
                    case (state)
                        S_IDLE: begin
                            out_data <= P_SYNC;
                            tx_err   <= ~rd_empty & ~rd_do[35];
                            state    <= (~rd_empty & rd_do[35]) ? S_XRDY : S_IDLE;
                        end
                        S_XRDY: begin
                            out_data <= P_XRDY;
                            if (rx_r_rdy) state <= S_SOF;
                        end
                        S_SOF: begin
                            out_data <= P_SOF;
                            crc      <= C_CRC_INIT;
                            state    <= S_DATA;
                        end
                        S_DATA: begin
                            out_data <= rx_hold ? P_HOLDA : rd_empty ? P_HOLD : rd_do[31:0];
                            out_isk  <= rx_hold | rd_empty;
                            if (rd_en) crc <= crc32(crc, rd_do[31:0]);
                            if (pop_eof) state <= S_CRC;
                        end
                        S_CRC: begin
                            out_data <= crc;
                            out_isk  <= 1'b0;
                            state    <= S_EOF;
                        end
                        S_EOF: begin
                            out_data <= P_EOF;
                            state    <= S_WTRM;
                        end
                        S_WTRM: begin
                            out_data <= P_WTRM;
                            if (rx_r_err || rx_r_ok || wtrm_cnt == WTRM_LAST) begin
                                tx_done  <= rx_r_ok & ~rx_r_err;
                                tx_err   <= rx_r_err | ~rx_r_ok;
                                wtrm_cnt <= '0;
                                state    <= S_IDLE;
                            end else begin
                                wtrm_cnt <= wtrm_cnt + 1'b1;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_txll_link_tx.sv
// tb_txll_link_tx: directed scoreboard bench for the SATA transmit link framer.
module tb_txll_link_tx;
    localparam logic [31:0] C_CRC_INIT = 32'h52325032;
    localparam int          C_WTRM_MAX = 1024;
    localparam logic [31:0] P_SYNC  = 32'hB5B5957C;
    localparam logic [31:0] P_XRDY  = 32'h5757B57C;
    localparam logic [31:0] P_SOF   = 32'h3737B57C;
    localparam logic [31:0] P_EOF   = 32'hD5D5B57C;
    localparam logic [31:0] P_WTRM  = 32'h5858B57C;
    localparam logic [31:0] P_HOLD  = 32'hD5D5AA7C;
    localparam logic [31:0] P_HOLDA = 32'h9595AA7C;

    logic sys_clk, sys_rst;
    logic [35:0] rd_do;
    logic rd_empty, rd_en, eof_poped;
    logic [31:0] out_data;
    logic out_isk, out_rdy;
    logic rx_r_rdy, rx_r_ok, rx_r_err, rx_hold, rx_sync;
    logic tx_done, tx_err;

    logic [35:0] fifo[$];
    logic [32:0] sb[$];
    bit strict, gate_empty;
    int checks, failures;
    int n_pop, n_done, n_err, n_eof, n_sync, n_xrdy, n_hold, n_holda, n_wtrm;

    txll_link_tx #(.C_CRC_INIT(C_CRC_INIT), .C_WTRM_MAX(C_WTRM_MAX)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rd_do(rd_do), .rd_empty(rd_empty),
        .rd_en(rd_en), .eof_poped(eof_poped), .out_data(out_data), .out_isk(out_isk),
        .out_rdy(out_rdy), .rx_r_rdy(rx_r_rdy), .rx_r_ok(rx_r_ok), .rx_r_err(rx_r_err),
        .rx_hold(rx_hold), .rx_sync(rx_sync), .tx_done(tx_done), .tx_err(tx_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word-at-a-time form of the MSB-first CRC: fold the dword in, then shift 32 times.
    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c ^ d;
        repeat (32) r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
        return r;
    endfunction

    task automatic push_frame(input int n, input logic [31:0] seed, input int n_emit);
        logic [31:0] c, d;
        c = C_CRC_INIT;
        for (int i = 0; i < n; i++) begin
            d = seed + 32'(i) * 32'h1F2E3D4C;
            fifo.push_back({i == 0, i == n - 1, 2'b00, d});
            c = crc_model(c, d);
            if (i < n_emit) sb.push_back({1'b0, d});
        end
        if (n_emit == n) sb.push_back({1'b0, c});
    endtask

    task automatic step();
        logic pop, rdy;
        logic [32:0] e;
        rd_empty = gate_empty || fifo.size() == 0;
        rd_do = (fifo.size() != 0) ? fifo[0] : 36'h0;
        #1;
        pop = rd_en;
        rdy = out_rdy;
        @(posedge sys_clk);
        #1;
        if (pop) begin
            void'(fifo.pop_front());
            n_pop++;
        end
        if (rdy && (strict || !out_isk)) begin
            chk("sb_nonempty", 36'(sb.size() != 0), 36'h1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("stream", {out_isk, out_data}, e);
            end
        end
        if (rdy && out_isk) begin
            n_sync  += int'(out_data == P_SYNC);
            n_xrdy  += int'(out_data == P_XRDY);
            n_hold  += int'(out_data == P_HOLD);
            n_holda += int'(out_data == P_HOLDA);
            n_wtrm  += int'(out_data == P_WTRM);
        end
        n_done += int'(tx_done);
        n_err  += int'(tx_err);
        n_eof  += int'(eof_poped);
        if (tx_done | tx_err) chk("done_err_excl", 36'(tx_done & tx_err), 36'h0);
    endtask

    task automatic start_frame();
        step();
        chk("idle_sync", {out_isk, out_data}, {1'b1, P_SYNC});
        rx_r_rdy = 1'b1;
        step();
        rx_r_rdy = 1'b0;
        chk("xrdy", {out_isk, out_data}, {1'b1, P_XRDY});
        step();
        chk("sof", {out_isk, out_data}, {1'b1, P_SOF});
    endtask

    task automatic run_to_wtrm();
        int w0;
        w0 = n_wtrm;
        for (int i = 0; i < 20 && n_wtrm == w0; i++) step();
        chk("wtrm_reached", 36'(n_wtrm != w0), 36'h1);
    endtask

    task automatic ack_ok();
        rx_r_ok = 1'b1;
        step();
        rx_r_ok = 1'b0;
        chk("tx_done", 36'(tx_done), 36'h1);
    endtask

    initial begin
        int p0, h0, e0, f0, x0, w0, d0;
        logic [31:0] held;
        checks = 0; failures = 0;
        sys_rst = 1'b1; out_rdy = 1'b1; rd_do = '0; rd_empty = 1'b1;
        rx_r_rdy = 0; rx_r_ok = 0; rx_r_err = 0; rx_hold = 0; rx_sync = 0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_out", {out_isk, out_data}, {1'b1, P_SYNC});
        chk("rst_rd_en", 36'(rd_en), 36'h0);
        chk("rst_pulses", {eof_poped, tx_done, tx_err}, 36'h0);
        sys_rst = 1'b0;

        // 3-dword frame, exact output stream
        strict = 1'b1;
        sb.push_back({1'b1, P_SYNC}); sb.push_back({1'b1, P_XRDY});
        sb.push_back({1'b1, P_XRDY}); sb.push_back({1'b1, P_SOF});
        push_frame(3, 32'hC0FFEE00, 3);
        sb.push_back({1'b1, P_EOF}); sb.push_back({1'b1, P_WTRM}); sb.push_back({1'b1, P_WTRM});
        f0 = n_eof;
        for (int i = 0; i < 11; i++) begin
            rx_r_rdy = (i == 2);
            rx_r_ok = (i == 10);
            step();
            if (i == 6) chk("eof_poped_d2", 36'(eof_poped), 36'h1);
            if (i == 7) chk("eof_poped_once", 36'(eof_poped), 36'h0);
        end
        rx_r_rdy = 1'b0; rx_r_ok = 1'b0;
        chk("f1_tx_done", 36'(tx_done), 36'h1);
        strict = 1'b0;
        step();
        chk("f1_tx_done_pulse", 36'(tx_done), 36'h0);
        chk("f1_eof_count", 36'(n_eof - f0), 36'h1);

        // out_rdy stall then FIFO underrun (HOLD)
        push_frame(3, 32'hA0000001, 3);
        start_frame();
        step();
        held = out_data;
        p0 = n_pop;
        out_rdy = 1'b0;
        repeat (2) step();
        out_rdy = 1'b1;
        chk("stall_data", 36'(out_data), 36'(held));
        chk("stall_nopop", 36'(n_pop - p0), 36'h0);
        gate_empty = 1'b1;
        h0 = n_hold;
        repeat (3) step();
        gate_empty = 1'b0;
        chk("hold_count", 36'(n_hold - h0), 36'h3);
        chk("hold_nopop", 36'(n_pop - p0), 36'h0);
        run_to_wtrm();
        ack_ok();

        // rx_hold mid-DATA (HOLDA)
        push_frame(4, 32'h12345678, 4);
        start_frame();
        step();
        p0 = n_pop; h0 = n_holda;
        rx_hold = 1'b1;
        step();
        chk("holda_rd_en", 36'(rd_en), 36'h0);
        step();
        rx_hold = 1'b0;
        chk("holda_count", 36'(n_holda - h0), 36'h2);
        chk("holda_nopop", 36'(n_pop - p0), 36'h0);
        run_to_wtrm();
        ack_ok();

        // rx_sync abort after d0 of a 4-dword frame
        push_frame(4, 32'h55AA0000, 1);
        start_frame();
        step();
        e0 = n_err; f0 = n_eof; p0 = n_pop; x0 = n_xrdy;
        rx_sync = 1'b1;
        step();
        rx_sync = 1'b0;
        chk("sync_err", 36'(tx_err), 36'h1);
        chk("sync_out", {out_isk, out_data}, {1'b1, P_SYNC});
        for (int i = 0; i < 10 && fifo.size() != 0; i++) step();
        repeat (2) step();
        chk("flush_pops", 36'(n_pop - p0), 36'h3);
        chk("flush_eof_once", 36'(n_eof - f0), 36'h1);
        chk("sync_err_once", 36'(n_err - e0), 36'h1);
        chk("flush_idle_sync", {out_isk, out_data}, {1'b1, P_SYNC});
        chk("flush_no_xrdy", 36'(n_xrdy - x0), 36'h0);

        // orphan entry in IDLE
        fifo.push_back({1'b0, 1'b0, 2'b00, 32'hDEADBEEF});
        x0 = n_xrdy;
        step();
        chk("orphan_err", 36'(tx_err), 36'h1);
        chk("orphan_popped", 36'(fifo.size()), 36'h0);
        repeat (2) step();
        chk("orphan_no_xrdy", 36'(n_xrdy - x0), 36'h0);

        // WTRM timeout
        push_frame(1, 32'h0F0F0F0F, 1);
        start_frame();
        w0 = n_wtrm; d0 = n_done;
        run_to_wtrm();
        for (int i = 0; i < C_WTRM_MAX + 50 && !tx_err; i++) step();
        chk("wtrm_timeout_err", 36'(tx_err), 36'h1);
        chk("wtrm_timeout_len", 36'(n_wtrm - w0), 36'(C_WTRM_MAX));
        chk("wtrm_timeout_nodone", 36'(n_done - d0), 36'h0);

        // R_OK and R_ERR together
        push_frame(2, 32'h77777777, 2);
        start_frame();
        run_to_wtrm();
        rx_r_ok = 1'b1; rx_r_err = 1'b1;
        step();
        rx_r_ok = 1'b0; rx_r_err = 1'b0;
        chk("both_err", 36'(tx_err), 36'h1);
        chk("both_nodone", 36'(tx_done), 36'h0);

        // asynchronous reset mid-frame
        push_frame(3, 32'h31415926, 1);
        start_frame();
        step();
        sys_rst = 1'b1;
        #2;
        chk("async_rst_out", {out_isk, out_data}, {1'b1, P_SYNC});
        fifo.delete();
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        push_frame(2, 32'h27182818, 2);
        start_frame();
        run_to_wtrm();
        ack_ok();

        chk("sb_drained", 36'(sb.size()), 36'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/txll_link_tx.md
# txll_link_tx

Transmit link-layer framer that drains the 36-bit frame FIFO filled by the transport-side TX FSM and drives the per-dword stream toward the scrambler/PHY. It runs the SATA transmit handshake (X_RDY/R_RDY, SOF, data, CRC, EOF, WTRM, R_OK/R_ERR), handles HOLD flow control and appends the frame CRC. It pulses `eof_poped` when a frame's last entry leaves the FIFO, which releases the upstream FSM's DONE state.

## Interface
- C_CRC_INIT, 32'h52325032, CRC seed loaded at SOF.
- C_WTRM_MAX, 1024, WTRM-state timeout in cycles before declaring error.
- sys_clk  in  1  sole clock; all logic on rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- rd_do  in  36  FIFO head (first-word-fall-through); [35]=SOF, [34]=EOF, [33:32] ignored, [31:0] data.
- rd_empty  in  1  FIFO empty.
- rd_en  out  1  pop FIFO head this cycle (combinational).
- eof_poped  out  1  one-cycle pulse, registered: the entry popped last cycle had [34]=1.
- out_data  out  32  dword to scrambler/PHY (registered).
- out_isk  out  1  1 = out_data is a primitive (K28.3 in byte 0).
- out_rdy  in  1  PHY accepts out_data this cycle; state only advances when 1.
- rx_r_rdy, rx_r_ok, rx_r_err, rx_hold, rx_sync  in  1 each  decoded primitives from the receive link, level while received.
- tx_done  out  1  pulse: frame acknowledged with R_OK.
- tx_err  out  1  pulse: R_ERR, SYNC abort, WTRM timeout, or orphan entry.

## Operation
- Primitives: SYNC B5B5957C, X_RDY 5757B57C, SOF 3737B57C, EOF D5D5B57C, WTRM 5858B57C, HOLD D5D5AA7C, HOLDA 9595AA7C.
- States: IDLE, XRDY, SOF, DATA, CRC, EOF, WTRM, FLUSH. Each transmitting state emits its value only on an out_rdy cycle; without out_rdy all registers hold.
- IDLE: emit SYNC. If ~rd_empty and rd_do[35]=1 -> XRDY. If ~rd_empty and rd_do[35]=0 (orphan): pop, pulse tx_err, stay IDLE.
- XRDY: emit X_RDY until rx_r_rdy -> SOF.
- SOF: emit SOF primitive once; CRC register := C_CRC_INIT -> DATA.
- DATA: if rx_hold emit HOLDA, no pop; else if rd_empty emit HOLD, no pop; else pop, emit rd_do[31:0] with isk=0, CRC := crc32(CRC, rd_do[31:0]). Popping an entry with [34]=1 -> CRC. rx_hold has priority over rd_empty.
- CRC: emit CRC register, isk=0 -> EOF. EOF: emit EOF -> WTRM.
- WTRM: emit WTRM; rx_r_ok -> pulse tx_done, IDLE; rx_r_err -> pulse tx_err, IDLE; if both high, R_ERR wins. Counter reaching C_WTRM_MAX -> tx_err, IDLE.
- rx_sync in XRDY/SOF/DATA/CRC/EOF (not IDLE/WTRM): pulse tx_err. From XRDY go to FLUSH; from SOF/DATA go to FLUSH unless the EOF entry was already popped (then IDLE); from CRC/EOF go IDLE.
- FLUSH: emit SYNC; pop every available entry regardless of out_rdy until an entry with [34]=1 is popped -> IDLE.
- CRC: SATA CRC-32, polynomial 04C11DB7, no reflection, no final inversion, dword MSB first, over data dwords only (SOF entry included).

## Timing
- Reset values: out_data=B5B5957C, out_isk=1, rd_en=0, eof_poped=0, tx_done=0, tx_err=0, state=IDLE, CRC=C_CRC_INIT, WTRM counter=0.
- rd_en = out_rdy & ~rd_empty & ~rx_hold in DATA; ~rd_empty in FLUSH; orphan pop in IDLE; 0 otherwise.
- Pipeline latency: a popped dword appears on out_data the next cycle.
- eof_poped is asserted the cycle after the popping edge and lasts exactly one cycle per EOF entry.
- tx_done and tx_err last one cycle and are never asserted together.
- Back-to-back frames: IDLE lasts at least one out_rdy cycle, so at least one SYNC separates them.
- Asynchronous reset mid-frame returns to IDLE immediately. The FIFO is not flushed by this block.

## Test plan
- 3-dword frame (SOF on first, EOF on third), out_rdy=1, R_RDY after 2 X_RDY: stream is SYNC, X_RDYx2, SOF, d0, d1, d2, CRC equal to the bench model, EOF, WTRM…; R_OK -> tx_done=1 for one cycle; eof_poped pulses the cycle after d2 is popped.
- FIFO empty after d0 for 3 cycles: HOLD emitted 3 times, no pops, and the CRC is unchanged by the HOLD cycles.
- rx_hold for 2 cycles mid-DATA with the FIFO non-empty: HOLDA x2, rd_en=0, data then resumes in order.
- rx_sync while in DATA after d0 of a 4-dword frame: tx_err pulse, then SYNC emitted while d1..d3 are flushed; eof_poped fires once and the block returns to IDLE.
- Orphan entry (bit35=0) at the head in IDLE: popped, tx_err pulse, no X_RDY emitted.
- WTRM with neither R_OK nor R_ERR for C_WTRM_MAX cycles: tx_err, IDLE. Also: R_OK and R_ERR high together -> tx_err only.
